// File: rtl/vga_ms_pkg.sv
// Timing-mode table and mode-FSM types shared by the multi-mode VGA timing generator.
package vga_ms_pkg;

  localparam int VGA_CNT_W = 11;

  typedef struct packed {
    logic [VGA_CNT_W-1:0] h_act;
    logic [VGA_CNT_W-1:0] h_fp;
    logic [VGA_CNT_W-1:0] h_sync;
    logic [VGA_CNT_W-1:0] h_bp;
    logic [VGA_CNT_W-1:0] v_act;
    logic [VGA_CNT_W-1:0] v_fp;
    logic [VGA_CNT_W-1:0] v_sync;
    logic [VGA_CNT_W-1:0] v_bp;
    logic                 hpol;
    logic                 vpol;
  } vga_mode_t;

  typedef enum logic {
    MS_IDLE,
    MS_PENDING
  } mode_state_e;

  localparam vga_mode_t VGA_MODE_640X480 = '{11'd640, 11'd16, 11'd96, 11'd48,
                                             11'd480, 11'd10, 11'd2, 11'd33, 1'b0, 1'b0};
  localparam vga_mode_t VGA_MODE_800X600 = '{11'd800, 11'd40, 11'd128, 11'd88,
                                             11'd600, 11'd1, 11'd4, 11'd23, 1'b1, 1'b1};
  localparam vga_mode_t VGA_MODE_TEST    = '{11'd8, 11'd2, 11'd2, 11'd2,
                                             11'd4, 11'd1, 11'd1, 11'd1, 1'b1, 1'b0};

  // Slots beyond the defined modes repeat mode 0 so a wider N_MODES still yields sane timing.
  localparam vga_mode_t VGA_MODES [8] = '{VGA_MODE_640X480, VGA_MODE_800X600, VGA_MODE_TEST,
                                          VGA_MODE_640X480, VGA_MODE_640X480, VGA_MODE_640X480,
                                          VGA_MODE_640X480, VGA_MODE_640X480};

endpackage

// File: rtl/vga_ms_decode.sv
// Single-axis decode of a position count: blanking, sync level at mode polarity, last-count flag.
// Purely combinational; the caller registers the results.
module vga_ms_decode #(
  parameter int CNT_W = 11
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] act,
  input  logic [CNT_W-1:0] fp,
  input  logic [CNT_W-1:0] sync,
  input  logic [CNT_W-1:0] bp,
  input  logic             pol,
  output logic             blank,
  output logic             sync_lvl,
  output logic             last
);

  logic [CNT_W-1:0] sync_beg;
  logic [CNT_W-1:0] sync_end;
  logic [CNT_W-1:0] total_m1;
  logic             in_win;

  always_comb begin
    sync_beg = act + fp;
    sync_end = sync_beg + sync;
    total_m1 = sync_end + bp - CNT_W'(1);
    in_win   = (cnt >= sync_beg) && (cnt < sync_end);
    blank    = (cnt >= act);
    sync_lvl = ~(in_win ^ pol);
    last     = (cnt == total_m1);
  end

endmodule

// File: rtl/vga_timing_ms.sv
// Multi-mode VGA timing generator; outputs lag the internal counters by one pix_en cycle.
// pix_en qualifies all counting; mode switches are deferred to the last pixel of a frame.
module vga_timing_ms
  import vga_ms_pkg::*;
#(
  parameter int        N_MODES   = 3,
  parameter int        CNT_W     = 11,
  parameter vga_mode_t MODES [8] = VGA_MODES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic [2:0]       mode_sel,
  input  logic             mode_req,
  output logic             mode_ack,
  output logic             mode_err,
  output logic [2:0]       cur_mode,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hblnk,
  output logic             vblnk,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start,
  output logic             line_start
);

  localparam logic [3:0] N_MODES_L = 4'(N_MODES);

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic [2:0]       act_mode;
  logic [2:0]       pend_mode;
  mode_state_e      state;
  vga_mode_t        m;

  logic h_blank, v_blank, h_sync_lvl, v_sync_lvl, h_last, v_last;
  logic sel_ok, switch_pt;

  assign m         = MODES[act_mode];
  assign sel_ok    = ({1'b0, mode_sel} < N_MODES_L);
  assign switch_pt = pix_en && (state == MS_PENDING) && h_last && v_last;

  vga_ms_decode #(.CNT_W(CNT_W)) u_hdec (
    .cnt      (h),
    .act      (CNT_W'(m.h_act)),
    .fp       (CNT_W'(m.h_fp)),
    .sync     (CNT_W'(m.h_sync)),
    .bp       (CNT_W'(m.h_bp)),
    .pol      (m.hpol),
    .blank    (h_blank),
    .sync_lvl (h_sync_lvl),
    .last     (h_last)
  );

  vga_ms_decode #(.CNT_W(CNT_W)) u_vdec (
    .cnt      (v),
    .act      (CNT_W'(m.v_act)),
    .fp       (CNT_W'(m.v_fp)),
    .sync     (CNT_W'(m.v_sync)),
    .bp       (CNT_W'(m.v_bp)),
    .pol      (m.vpol),
    .blank    (v_blank),
    .sync_lvl (v_sync_lvl),
    .last     (v_last)
  );

  // Counters and the registered view of them; everything holds while pix_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      h           <= '0;
      v           <= '0;
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~MODES[0].hpol;
      vsync       <= ~MODES[0].vpol;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      cur_mode    <= '0;
    end else if (pix_en) begin
      hcount      <= h;
      vcount      <= v;
      hblnk       <= h_blank;
      vblnk       <= v_blank;
      hsync       <= h_sync_lvl;
      vsync       <= v_sync_lvl;
      de          <= ~h_blank & ~v_blank;
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
      cur_mode    <= act_mode;
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + CNT_W'(1);
      end else begin
        h <= h + CNT_W'(1);
      end
    end
  end

  // A request landing on the switch cycle re-arms PENDING for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MS_IDLE;
      pend_mode <= '0;
      act_mode  <= '0;
      mode_ack  <= 1'b0;
      mode_err  <= 1'b0;
    end else begin
      mode_ack <= switch_pt;
      mode_err <= mode_req & ~sel_ok;
      if (switch_pt) begin
        act_mode <= pend_mode;
      end
      case (state)
        MS_IDLE: begin
          if (mode_req && sel_ok) begin
            pend_mode <= mode_sel;
            state     <= MS_PENDING;
          end
        end
        MS_PENDING: begin
          if (mode_req && sel_ok) begin
            pend_mode <= mode_sel;
          end else if (switch_pt) begin
            state <= MS_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_timing_ms.sv
// Two instances: the shipped mode table (mode 0 line checks) and a shrunken table that
// keeps frames short enough to exercise mode switching against a behavioural model.
module tb_vga_timing_ms;
  import vga_ms_pkg::*;

  localparam vga_mode_t SPEC_TAB [8] = '{
    '{11'd640, 11'd16, 11'd96, 11'd48, 11'd480, 11'd10, 11'd2, 11'd33, 1'b0, 1'b0},
    '{11'd800, 11'd40, 11'd128, 11'd88, 11'd600, 11'd1, 11'd4, 11'd23, 1'b1, 1'b1},
    '{11'd8, 11'd2, 11'd2, 11'd2, 11'd4, 11'd1, 11'd1, 11'd1, 1'b1, 1'b0},
    '{11'd640, 11'd16, 11'd96, 11'd48, 11'd480, 11'd10, 11'd2, 11'd33, 1'b0, 1'b0},
    '{11'd640, 11'd16, 11'd96, 11'd48, 11'd480, 11'd10, 11'd2, 11'd33, 1'b0, 1'b0},
    '{11'd640, 11'd16, 11'd96, 11'd48, 11'd480, 11'd10, 11'd2, 11'd33, 1'b0, 1'b0},
    '{11'd640, 11'd16, 11'd96, 11'd48, 11'd480, 11'd10, 11'd2, 11'd33, 1'b0, 1'b0},
    '{11'd640, 11'd16, 11'd96, 11'd48, 11'd480, 11'd10, 11'd2, 11'd33, 1'b0, 1'b0}};

  // Small table: mode 0 is 10x6, mode 1 is 11x7, mode 2 is the shipped test mode (14x7).
  localparam vga_mode_t TB_TAB [8] = '{
    '{11'd6, 11'd1, 11'd2, 11'd1, 11'd3, 11'd1, 11'd1, 11'd1, 1'b0, 1'b0},
    '{11'd5, 11'd2, 11'd1, 11'd3, 11'd2, 11'd2, 11'd2, 11'd1, 1'b1, 1'b1},
    '{11'd8, 11'd2, 11'd2, 11'd2, 11'd4, 11'd1, 11'd1, 11'd1, 1'b1, 1'b0},
    '{11'd6, 11'd1, 11'd2, 11'd1, 11'd3, 11'd1, 11'd1, 11'd1, 1'b0, 1'b0},
    '{11'd6, 11'd1, 11'd2, 11'd1, 11'd3, 11'd1, 11'd1, 11'd1, 1'b0, 1'b0},
    '{11'd6, 11'd1, 11'd2, 11'd1, 11'd3, 11'd1, 11'd1, 11'd1, 1'b0, 1'b0},
    '{11'd6, 11'd1, 11'd2, 11'd1, 11'd3, 11'd1, 11'd1, 11'd1, 1'b0, 1'b0},
    '{11'd6, 11'd1, 11'd2, 11'd1, 11'd3, 11'd1, 11'd1, 11'd1, 1'b0, 1'b0}};

  typedef struct packed {
    int h; int v; int mode; int pend; bit pendv;
    int hcount; int vcount; int cur;
    bit hblnk; bit vblnk; bit hsync; bit vsync; bit de; bit fs; bit ls; bit ack; bit err;
  } mstate_t;

  logic clk, rst, pix_en, mode_req;
  logic [2:0] mode_sel;
  logic a_ack, a_err, a_hb, a_vb, a_hs, a_vs, a_de, a_fs, a_ls;
  logic b_ack, b_err, b_hb, b_vb, b_hs, b_vs, b_de, b_fs, b_ls;
  logic [2:0] a_cur, b_cur;
  logic [10:0] a_hc, a_vc, b_hc, b_vc;
  logic [33:0] a_vec, b_vec;

  mstate_t mA, mB;
  bit started;
  int cyc, n_vec, n_err;
  int hs_cnt, hb_cnt, hs_min, hs_max, last_fs, fs_period, acks, acks_a;
  int since, line_len, hmax, vs_min, vs_max, nfs, de_frame, waited;
  bit upd, ls_seen;

  vga_timing_ms #(.N_MODES(3), .CNT_W(11)) dut_a (
    .clk(clk), .rst(rst), .pix_en(pix_en), .mode_sel(mode_sel), .mode_req(mode_req),
    .mode_ack(a_ack), .mode_err(a_err), .cur_mode(a_cur), .hcount(a_hc), .vcount(a_vc),
    .hblnk(a_hb), .vblnk(a_vb), .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .frame_start(a_fs), .line_start(a_ls));

  vga_timing_ms #(.N_MODES(3), .CNT_W(11), .MODES(TB_TAB)) dut_b (
    .clk(clk), .rst(rst), .pix_en(pix_en), .mode_sel(mode_sel), .mode_req(mode_req),
    .mode_ack(b_ack), .mode_err(b_err), .cur_mode(b_cur), .hcount(b_hc), .vcount(b_vc),
    .hblnk(b_hb), .vblnk(b_vb), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .frame_start(b_fs), .line_start(b_ls));

  assign a_vec = {a_hc, a_vc, a_hb, a_vb, a_hs, a_vs, a_de, a_fs, a_ls, a_ack, a_err, a_cur};
  assign b_vec = {b_hc, b_vc, b_hb, b_vb, b_hs, b_vs, b_de, b_fs, b_ls, b_ack, b_err, b_cur};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vga_mode_t tab(int inst, int m);
    return (inst == 0) ? SPEC_TAB[m] : TB_TAB[m];
  endfunction

  // Reference: position within the frame plus a one-deep request mailbox.
  function automatic mstate_t step(mstate_t s, int inst, bit r, bit pe, bit req, int sel);
    vga_mode_t t;
    int ht, vt, hsb, vsb;
    bit sw;
    if (r) begin
      s = '0;
      s.hsync = !tab(inst, 0).hpol;
      s.vsync = !tab(inst, 0).vpol;
      return s;
    end
    s.ack = 1'b0;
    s.err = 1'b0;
    t   = tab(inst, s.mode);
    hsb = int'(t.h_act) + int'(t.h_fp);
    vsb = int'(t.v_act) + int'(t.v_fp);
    ht  = hsb + int'(t.h_sync) + int'(t.h_bp);
    vt  = vsb + int'(t.v_sync) + int'(t.v_bp);
    sw  = pe && s.pendv && (s.h == ht - 1) && (s.v == vt - 1);
    if (pe) begin
      s.hcount = s.h;
      s.vcount = s.v;
      s.hblnk  = (s.h >= int'(t.h_act));
      s.vblnk  = (s.v >= int'(t.v_act));
      s.hsync  = ((s.h >= hsb) && (s.h < hsb + int'(t.h_sync))) ? t.hpol : !t.hpol;
      s.vsync  = ((s.v >= vsb) && (s.v < vsb + int'(t.v_sync))) ? t.vpol : !t.vpol;
      s.de     = !s.hblnk && !s.vblnk;
      s.ls     = (s.h == 0);
      s.fs     = (s.h == 0) && (s.v == 0);
      s.cur    = s.mode;
      s.h = (s.h + 1) % ht;
      if (s.h == 0) s.v = (s.v + 1) % vt;
    end
    if (sw) begin
      s.mode  = s.pend;
      s.pendv = 1'b0;
      s.ack   = 1'b1;
    end
    if (req) begin
      if (sel < 3) begin
        s.pend  = sel;
        s.pendv = 1'b1;
      end else begin
        s.err = 1'b1;
      end
    end
    return s;
  endfunction

  function automatic logic [33:0] pk(mstate_t s);
    return {11'(s.hcount), 11'(s.vcount), s.hblnk, s.vblnk, s.hsync, s.vsync, s.de,
            s.fs, s.ls, s.ack, s.err, 3'(s.cur)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, want);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    mA = step(mA, 0, rst, pix_en, mode_req, int'(mode_sel));
    mB = step(mB, 1, rst, pix_en, mode_req, int'(mode_sel));
    if (rst) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("dut_a_outputs", 64'(a_vec), 64'(pk(mA)));
      check("dut_b_outputs", 64'(b_vec), 64'(pk(mB)));
    end
  end

  initial begin
    rst = 1'b1; pix_en = 1'b0; mode_req = 1'b0; mode_sel = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_a", 64'(a_vec), 64'({22'd0, 9'b0011_00000, 3'd0}));
    check("reset_b", 64'(b_vec), 64'({22'd0, 9'b0011_00000, 3'd0}));

    // Continuous pix_en in mode 0: inspect line 0 of the shipped 640x480 timing.
    rst = 1'b0; pix_en = 1'b1;
    hs_min = 9999; hs_max = -1; last_fs = -1;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      if (a_vc == 11'd0) begin
        if (!a_hs) begin
          hs_cnt++;
          if (int'(a_hc) < hs_min) hs_min = int'(a_hc);
          if (int'(a_hc) > hs_max) hs_max = int'(a_hc);
        end
        if (a_hb) hb_cnt++;
      end
      if (b_fs) begin
        if (last_fs >= 0) fs_period = cyc - last_fs;
        last_fs = cyc;
      end
    end
    check("m0_hsync_low_len", 64'(hs_cnt), 64'd96);
    check("m0_hsync_first", 64'(hs_min), 64'd656);
    check("m0_hsync_last", 64'(hs_max), 64'd751);
    check("m0_hblnk_len", 64'(hb_cnt), 64'd160);
    check("b_frame_period", 64'(fs_period), 64'd60);

    // Out-of-range request.
    mode_req = 1'b1; mode_sel = 3'd5;
    @(negedge clk);
    mode_req = 1'b0; mode_sel = 3'd0;
    check("err_pulse", 64'({a_err, b_err}), 64'd3);
    @(negedge clk);
    check("err_clears", 64'({a_err, b_err}), 64'd0);

    // Two requests within one frame on the short-table instance: one ack, mode 2 wins.
    waited = 0;
    while (!(mB.v == 2 && mB.h == 3) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("wait_mid_frame", 64'(waited < 200), 64'd1);
    mode_req = 1'b1; mode_sel = 3'd1;
    @(negedge clk);
    mode_req = 1'b0;
    repeat (4) @(negedge clk);
    mode_req = 1'b1; mode_sel = 3'd2;
    @(negedge clk);
    mode_req = 1'b0; mode_sel = 3'd0;
    acks = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (b_ack) acks++;
    end
    check("double_req_acks", 64'(acks), 64'd1);
    check("double_req_mode", 64'(b_cur), 64'd2);

    // Test mode with pix_en every third clock.
    hs_min = 9999; hs_max = -1; vs_min = 9999; vs_max = -1; hmax = -1;
    since = 0; ls_seen = 1'b0; nfs = 0; de_frame = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      upd = pix_en;
      if (upd) begin
        since++;
        if (b_ls) begin
          if (ls_seen) line_len = since;
          since = 0;
          ls_seen = 1'b1;
        end
        if (int'(b_hc) > hmax) hmax = int'(b_hc);
        if (b_hs) begin
          if (int'(b_hc) < hs_min) hs_min = int'(b_hc);
          if (int'(b_hc) > hs_max) hs_max = int'(b_hc);
        end
        if (!b_vs) begin
          if (int'(b_vc) < vs_min) vs_min = int'(b_vc);
          if (int'(b_vc) > vs_max) vs_max = int'(b_vc);
        end
        if (b_fs) nfs++;
        if (nfs == 1 && b_de) de_frame++;
      end
      pix_en = (i % 3 == 2);
    end
    check("m2_line_len", 64'(line_len), 64'd14);
    check("m2_hcount_max", 64'(hmax), 64'd13);
    check("m2_hsync_first", 64'(hs_min), 64'd10);
    check("m2_hsync_last", 64'(hs_max), 64'd11);
    check("m2_vsync_first", 64'(vs_min), 64'd5);
    check("m2_vsync_last", 64'(vs_max), 64'd5);
    check("m2_de_per_frame", 64'(de_frame), 64'd32);

    // Reset one cycle after a fresh request, with mode-0 h at 300.
    pix_en = 1'b1;
    waited = 0;
    while (mA.h != 299 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("wait_h299", 64'(waited < 2000), 64'd1);
    mode_req = 1'b1; mode_sel = 3'd1;
    @(negedge clk);
    mode_req = 1'b0; mode_sel = 3'd0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_discard_a", 64'({a_hc, a_vc, a_cur}), 64'd0);
    check("rst_discard_b_mode", 64'(b_cur), 64'd0);
    acks = 0; acks_a = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_ack) acks++;
      if (a_ack) acks_a++;
    end
    check("rst_discard_b_acks", 64'(acks), 64'd0);
    check("rst_discard_a_acks", 64'(acks_a), 64'd0);
    check("rst_discard_b_mode_after", 64'(b_cur), 64'd0);

    // Randomised traffic, all cycles checked against the model.
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      pix_en   = ($urandom_range(0, 9) < 7);
      mode_req = ($urandom_range(0, 29) == 0);
      mode_sel = 3'($urandom_range(0, 7));
      rst      = ($urandom_range(0, 1999) == 0);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
